// File: rtl/mem_access_unit_pkg.sv
// Shared encodings for the MEM-stage data-memory access unit.
package mem_access_pkg;

    localparam logic [1:0] SZ_BYTE = 2'b00;
    localparam logic [1:0] SZ_HALF = 2'b01;
    localparam logic [1:0] SZ_WORD = 2'b10;

    typedef enum logic [1:0] {
        IDLE   = 2'b00,
        ACCESS = 2'b01,
        WAIT   = 2'b10,
        WRITE  = 2'b11
    } state_t;

    // Size 2'b11 falls into the default arm and is handled as a word.
    function automatic logic is_misaligned(input logic [1:0] size, input logic [1:0] lane);
        case (size)
            SZ_BYTE: return 1'b0;
            SZ_HALF: return lane[0];
            default: return (lane != 2'b00);
        endcase
    endfunction

endpackage

// File: rtl/mem_access_unit_if.sv
// Pipeline request/response handshake plus the data-memory bus.
// The unit uses the slave view; the surrounding pipeline/memory uses the master view.
interface mem_access_unit_if;

    logic        ReqValid;
    logic        ReqReady;
    logic        ReqWrite;
    logic [1:0]  ReqSize;
    logic        ReqSigned;
    logic [31:0] ReqAddr;
    logic [31:0] ReqWData;
    logic        RespValid;
    logic [31:0] RespData;
    logic        StoreDone;
    logic        AddrError;
    logic [31:0] MemAddress;
    logic [31:0] MemWriteData;
    logic        MemWrite;
    logic        MemRead;
    logic [31:0] MemReadData;

    modport slave (
        input  ReqValid, ReqWrite, ReqSize, ReqSigned, ReqAddr, ReqWData, MemReadData,
        output ReqReady, RespValid, RespData, StoreDone, AddrError,
               MemAddress, MemWriteData, MemWrite, MemRead
    );

    modport master (
        output ReqValid, ReqWrite, ReqSize, ReqSigned, ReqAddr, ReqWData, MemReadData,
        input  ReqReady, RespValid, RespData, StoreDone, AddrError,
               MemAddress, MemWriteData, MemWrite, MemRead
    );

endinterface

// File: rtl/mem_access_unit_lane_align.sv
// Little-endian lane handling: extract and extend a load lane, or merge a
// store lane into the word just read from memory.
module mau_lane_align
    import mem_access_pkg::*;
(
    input  logic [31:0] rdata_i,
    input  logic [1:0]  lane_i,
    input  logic [1:0]  size_i,
    input  logic        signed_i,
    input  logic [31:0] wdata_i,
    output logic [31:0] load_o,
    output logic [31:0] merged_o
);

    logic [4:0]  byte_sh;
    logic [4:0]  half_sh;
    logic [7:0]  byte_sel;
    logic [15:0] half_sel;

    assign byte_sh = {lane_i, 3'b000};
    assign half_sh = {lane_i[1], 4'b0000};

    // Select the addressed lane and extend it to 32 bits.
    always_comb begin
        byte_sel = 8'(rdata_i >> byte_sh);
        half_sel = 16'(rdata_i >> half_sh);
        case (size_i)
            SZ_BYTE: load_o = signed_i ? {{24{byte_sel[7]}}, byte_sel} : {24'b0, byte_sel};
            SZ_HALF: load_o = signed_i ? {{16{half_sel[15]}}, half_sel} : {16'b0, half_sel};
            default: load_o = rdata_i;
        endcase
    end

    // Replace only the addressed lane; other lanes keep the read data.
    always_comb begin
        case (size_i)
            SZ_BYTE: merged_o = (rdata_i & ~(32'h0000_00FF << byte_sh))
                              | ({24'b0, wdata_i[7:0]} << byte_sh);
            SZ_HALF: merged_o = (rdata_i & ~(32'h0000_FFFF << half_sh))
                              | ({16'b0, wdata_i[15:0]} << half_sh);
            default: merged_o = wdata_i;
        endcase
    end

endmodule

// File: rtl/mem_access_unit.sv
// MEM-stage initiator: one load/store at a time, alignment checks,
// read-modify-write for sub-word stores, extended load data.
module mem_access_unit
    import mem_access_pkg::*;
#(
    parameter int ADDR_W = 10
) (
    input  logic             Clk,
    input  logic             Reset_n,
    mem_access_unit_if.slave bus
);

    state_t            state_q;
    logic              ready_q;
    logic              resp_valid_q;
    logic [31:0]       resp_data_q;
    logic              store_done_q;
    logic              addr_err_q;
    logic              write_q;
    logic              signed_q;
    logic [1:0]        size_q;
    logic [ADDR_W+1:0] addr_q;
    logic [31:0]       wdata_q;
    logic [31:0]       merged_q;
    logic [31:0]       load_d;
    logic [31:0]       merged_d;
    logic [31:0]       word_addr;
    logic              word_store;
    logic              unused_addr_hi;

    // Bytes above the memory size wrap, so the high address bits are ignored.
    assign unused_addr_hi = ^bus.ReqAddr[31:ADDR_W+2];
    assign word_addr      = {{(32-ADDR_W){1'b0}}, addr_q[ADDR_W+1:2]};
    assign word_store     = write_q && size_q[1];

    mau_lane_align u_align (
        .rdata_i  (bus.MemReadData),
        .lane_i   (addr_q[1:0]),
        .size_i   (size_q),
        .signed_i (signed_q),
        .wdata_i  (wdata_q),
        .load_o   (load_d),
        .merged_o (merged_d)
    );

    assign bus.ReqReady  = ready_q;
    assign bus.RespValid = resp_valid_q;
    assign bus.RespData  = resp_data_q;
    assign bus.StoreDone = store_done_q;
    assign bus.AddrError = addr_err_q;

    // Request sequencing with registered handshake/response outputs.
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            state_q      <= IDLE;
            ready_q      <= 1'b1;
            resp_valid_q <= 1'b0;
            resp_data_q  <= '0;
            store_done_q <= 1'b0;
            addr_err_q   <= 1'b0;
            write_q      <= 1'b0;
            signed_q     <= 1'b0;
            size_q       <= '0;
            addr_q       <= '0;
            wdata_q      <= '0;
            merged_q     <= '0;
        end else begin
            resp_valid_q <= 1'b0;
            store_done_q <= 1'b0;
            addr_err_q   <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (bus.ReqValid) begin
                        if (is_misaligned(bus.ReqSize, bus.ReqAddr[1:0])) begin
                            addr_err_q <= 1'b1;
                        end else begin
                            write_q  <= bus.ReqWrite;
                            signed_q <= bus.ReqSigned;
                            size_q   <= bus.ReqSize;
                            addr_q   <= bus.ReqAddr[ADDR_W+1:0];
                            wdata_q  <= bus.ReqWData;
                            ready_q  <= 1'b0;
                            state_q  <= ACCESS;
                        end
                    end
                end
                ACCESS: begin
                    if (word_store) begin
                        store_done_q <= 1'b1;
                        ready_q      <= 1'b1;
                        state_q      <= IDLE;
                    end else begin
                        state_q <= WAIT;
                    end
                end
                WAIT: begin
                    if (!write_q) begin
                        resp_data_q  <= load_d;
                        resp_valid_q <= 1'b1;
                        ready_q      <= 1'b1;
                        state_q      <= IDLE;
                    end else begin
                        merged_q <= merged_d;
                        state_q  <= WRITE;
                    end
                end
                WRITE: begin
                    store_done_q <= 1'b1;
                    ready_q      <= 1'b1;
                    state_q      <= IDLE;
                end
                default: begin
                    ready_q <= 1'b1;
                    state_q <= IDLE;
                end
            endcase
        end
    end

    // Memory bus decoded from state; everything is 0 in IDLE and during reset.
    always_comb begin
        bus.MemAddress   = '0;
        bus.MemWriteData = '0;
        bus.MemWrite     = 1'b0;
        bus.MemRead      = 1'b0;
        case (state_q)
            ACCESS: begin
                bus.MemAddress = word_addr;
                bus.MemRead    = 1'b1;
                if (word_store) begin
                    bus.MemWrite     = 1'b1;
                    bus.MemWriteData = wdata_q;
                end
            end
            WAIT: begin
                bus.MemAddress = word_addr;
            end
            WRITE: begin
                bus.MemAddress   = word_addr;
                bus.MemWrite     = 1'b1;
                bus.MemWriteData = merged_q;
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_mem_access_unit.sv
// Bench for mem_access_unit: directed table, randomized requests against a
// byte-array memory model, back-to-back stall and mid-operation reset.
module tb_mem_access_unit;

    localparam logic [1:0] B = 2'b00;
    localparam logic [1:0] H = 2'b01;
    localparam logic [1:0] W = 2'b10;

    logic Clk;
    logic Reset_n;

    mem_access_unit_if bus ();

    mem_access_unit #(.ADDR_W(10)) dut (
        .Clk     (Clk),
        .Reset_n (Reset_n),
        .bus     (bus)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    // Synchronous-read word memory with a bench-side preload port.
    logic [31:0] mem [1024];
    logic        pl_we;
    logic [9:0]  pl_addr;
    logic [31:0] pl_data;

    always @(posedge Clk) begin
        if (pl_we) mem[pl_addr] <= pl_data;
        else if (bus.MemWrite) mem[bus.MemAddress[9:0]] <= bus.MemWriteData;
        bus.MemReadData <= mem[bus.MemAddress[9:0]];
    end

    // Reference model: memory as 4096 little-endian bytes.
    logic [7:0] ref_mem [4096];

    int n_checks = 0;
    int n_errors = 0;

    typedef struct {
        logic        wr;
        logic [1:0]  sz;
        logic        sg;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] expv;
    } vec_t;

    typedef struct {
        int          rv_cnt, sd_cnt, ae_cnt;
        int          rv_cyc, sd_cyc, ae_cyc;
        int          wr_cnt, wr_cyc, rd_cnt;
        logic [31:0] data;
        logic [31:0] maddr;
        logic [6:0]  rdy;
    } obs_t;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    function automatic int nbytes(input logic [1:0] sz);
        if (sz == 2'b00) return 1;
        if (sz == 2'b01) return 2;
        return 4;
    endfunction

    function automatic bit model_misal(input logic [1:0] sz, input logic [31:0] a);
        return (a % nbytes(sz)) != 0;
    endfunction

    function automatic logic [31:0] model_load(input logic [1:0] sz, input logic sg, input logic [31:0] a);
        int          n;
        logic [31:0] v;
        n = nbytes(sz);
        v = 0;
        for (int i = 0; i < n; i++) v = v | (32'(ref_mem[12'(a + 32'(i))]) << (8 * i));
        if (sg && n < 4 && v[8*n-1]) v = v | (32'hFFFF_FFFF << (8 * n));
        return v;
    endfunction

    task automatic model_store(input logic [1:0] sz, input logic [31:0] a, input logic [31:0] d);
        for (int i = 0; i < nbytes(sz); i++) ref_mem[12'(a + 32'(i))] = 8'(d >> (8 * i));
    endtask

    function automatic logic [31:0] ref_word(input int idx);
        logic [31:0] v;
        v = 0;
        for (int i = 0; i < 4; i++) v = v | (32'(ref_mem[12'(idx * 4 + i)]) << (8 * i));
        return v;
    endfunction

    task automatic preload(input int idx, input logic [31:0] d);
        pl_we   = 1'b1;
        pl_addr = 10'(idx);
        pl_data = d;
        for (int i = 0; i < 4; i++) ref_mem[12'(idx * 4 + i)] = 8'(d >> (8 * i));
        @(negedge Clk);
        pl_we = 1'b0;
    endtask

    task automatic idle_inputs();
        bus.ReqValid  = 1'b0;
        bus.ReqWrite  = 1'b0;
        bus.ReqSize   = 2'b00;
        bus.ReqSigned = 1'b0;
        bus.ReqAddr   = 32'h0;
        bus.ReqWData  = 32'h0;
    endtask

    // Issue one request at a negedge and record six cycles of outputs after acceptance.
    task automatic run_req(input vec_t v, output obs_t o);
        int guard;
        o.rv_cnt = 0; o.sd_cnt = 0; o.ae_cnt = 0;
        o.rv_cyc = 0; o.sd_cyc = 0; o.ae_cyc = 0;
        o.wr_cnt = 0; o.wr_cyc = 0; o.rd_cnt = 0;
        o.data = 0; o.maddr = 0; o.rdy = 0;
        guard = 0;
        while (bus.ReqReady !== 1'b1 && guard < 10) begin
            @(negedge Clk);
            guard++;
        end
        if (guard >= 10) begin
            n_checks++;
            n_errors++;
            $display("FAIL ready_timeout: ReqReady still 0 after %0d cycles, expected 1", guard);
        end
        bus.ReqValid  = 1'b1;
        bus.ReqWrite  = v.wr;
        bus.ReqSize   = v.sz;
        bus.ReqSigned = v.sg;
        bus.ReqAddr   = v.addr;
        bus.ReqWData  = v.wdata;
        @(negedge Clk);
        bus.ReqValid = 1'b0;
        for (int k = 1; k <= 6; k++) begin
            o.rdy[k] = bus.ReqReady;
            if (bus.RespValid) begin o.rv_cnt++; if (o.rv_cyc == 0) o.rv_cyc = k; o.data = bus.RespData; end
            if (bus.StoreDone) begin o.sd_cnt++; if (o.sd_cyc == 0) o.sd_cyc = k; end
            if (bus.AddrError) begin o.ae_cnt++; if (o.ae_cyc == 0) o.ae_cyc = k; end
            if (bus.MemWrite)  begin o.wr_cnt++; o.wr_cyc = k; end
            if (bus.MemRead)   o.rd_cnt++;
            if (k == 1) o.maddr = bus.MemAddress;
            if (k < 6) @(negedge Clk);
        end
    endtask

    function automatic logic [31:0] pack3(input int a, input int b, input int c);
        return (32'(a) << 16) | (32'(b) << 8) | 32'(c);
    endfunction

    task automatic evaluate(input string tag, input vec_t v, input obs_t o, input logic [31:0] exp_val);
        bit          err;
        int          lat;
        logic [6:0]  rdy_exp;
        logic [31:0] idx;
        err = model_misal(v.sz, v.addr);
        idx = (v.addr >> 2) & 32'h3FF;
        if (err) lat = 1;
        else if (!v.wr) lat = 3;
        else if (v.sz[1]) lat = 2;
        else lat = 4;
        rdy_exp = 0;
        for (int k = 1; k <= 6; k++) rdy_exp[k] = err || (k >= lat);
        check({tag, "_ready"}, {25'b0, o.rdy}, {25'b0, rdy_exp});
        if (err) begin
            check({tag, "_err_cycle"}, 32'(o.ae_cyc), 32'd1);
            check({tag, "_pulses"}, pack3(o.rv_cnt, o.sd_cnt, o.ae_cnt), pack3(0, 0, 1));
            check({tag, "_no_strobe"}, pack3(0, o.wr_cnt, o.rd_cnt), 32'd0);
        end else if (!v.wr) begin
            check({tag, "_resp_cycle"}, 32'(o.rv_cyc), 32'(lat));
            check({tag, "_pulses"}, pack3(o.rv_cnt, o.sd_cnt, o.ae_cnt), pack3(1, 0, 0));
            check({tag, "_data"}, o.data, exp_val);
            check({tag, "_no_write"}, 32'(o.wr_cnt), 32'd0);
            check({tag, "_read"}, {31'b0, (o.rd_cnt != 0)}, 32'd1);
            check({tag, "_maddr"}, o.maddr, idx);
        end else begin
            check({tag, "_done_cycle"}, 32'(o.sd_cyc), 32'(lat));
            check({tag, "_pulses"}, pack3(o.rv_cnt, o.sd_cnt, o.ae_cnt), pack3(0, 1, 0));
            check({tag, "_write"}, pack3(0, o.wr_cnt, o.wr_cyc), pack3(0, 1, lat - 1));
            check({tag, "_maddr"}, o.maddr, idx);
            check({tag, "_mem"}, mem[idx[9:0]], exp_val);
        end
    endtask

    vec_t tbl [18];

    initial begin
        obs_t        o;
        vec_t        v;
        logic [31:0] e;
        int          cnt_rv, cnt_sd, cnt_wr;

        Reset_n = 1'b0;
        pl_we   = 1'b0;
        pl_addr = '0;
        pl_data = '0;
        idle_inputs();

        tbl[0]  = '{1'b0, B, 1'b1, 32'h11,   32'h0,        32'h0000_0043};
        tbl[1]  = '{1'b0, B, 1'b1, 32'h13,   32'h0,        32'hFFFF_FF87};
        tbl[2]  = '{1'b0, H, 1'b0, 32'h12,   32'h0,        32'h0000_8765};
        tbl[3]  = '{1'b0, H, 1'b1, 32'h12,   32'h0,        32'hFFFF_8765};
        tbl[4]  = '{1'b0, B, 1'b0, 32'h13,   32'h0,        32'h0000_0087};
        tbl[5]  = '{1'b0, W, 1'b0, 32'h10,   32'h0,        32'h8765_4321};
        tbl[6]  = '{1'b0, H, 1'b1, 32'h11,   32'h0,        32'h0};
        tbl[7]  = '{1'b1, W, 1'b0, 32'h12,   32'h5555_5555, 32'h0};
        tbl[8]  = '{1'b1, B, 1'b0, 32'h10,   32'h1234_56AA, 32'h8765_43AA};
        tbl[9]  = '{1'b0, 2'b11, 1'b0, 32'h10, 32'h0,      32'h8765_43AA};
        tbl[10] = '{1'b1, W, 1'b0, 32'h1000, 32'hDEAD_BEEF, 32'hDEAD_BEEF};
        tbl[11] = '{1'b1, H, 1'b0, 32'h16,   32'hFFFF_1234, 32'h1234_0000};
        tbl[12] = '{1'b0, H, 1'b1, 32'h16,   32'h0,        32'h0000_1234};
        tbl[13] = '{1'b1, B, 1'b0, 32'h17,   32'h0000_00CD, 32'hCD34_0000};
        tbl[14] = '{1'b0, B, 1'b1, 32'h17,   32'h0,        32'hFFFF_FFCD};
        tbl[15] = '{1'b1, H, 1'b0, 32'h10,   32'h0000_BEEF, 32'h8765_BEEF};
        tbl[16] = '{1'b0, B, 1'b1, 32'h1011, 32'h0,        32'hFFFF_FFBE};
        tbl[17] = '{1'b0, W, 1'b0, 32'h0,    32'h0,        32'hDEAD_BEEF};

        repeat (3) @(negedge Clk);
        check("rst_strobes", {27'b0, bus.RespValid, bus.StoreDone, bus.AddrError, bus.MemWrite, bus.MemRead}, 32'd0);
        check("rst_respdata", bus.RespData, 32'd0);
        check("rst_memaddr", bus.MemAddress, 32'd0);
        Reset_n = 1'b1;
        @(negedge Clk);
        check("rst_ready", {31'b0, bus.ReqReady}, 32'd1);
        check("rst_wdata", bus.MemWriteData, 32'd0);

        for (int i = 0; i < 1024; i++) preload(i, 32'h0);
        preload(4, 32'h8765_4321);

        for (int i = 0; i < 18; i++) begin
            run_req(tbl[i], o);
            if (tbl[i].wr && !model_misal(tbl[i].sz, tbl[i].addr)) model_store(tbl[i].sz, tbl[i].addr, tbl[i].wdata);
            evaluate($sformatf("tbl%0d", i), tbl[i], o, tbl[i].expv);
        end

        for (int i = 0; i < 80; i++) begin
            v.wr    = 1'($urandom_range(0, 1));
            v.sz    = 2'($urandom_range(0, 3));
            v.sg    = 1'($urandom_range(0, 1));
            v.addr  = 32'($urandom_range(0, 63));
            if ($urandom_range(0, 3) == 0) v.addr = v.addr | ($urandom & 32'hFFFF_F000);
            v.wdata = $urandom;
            v.expv  = 0;
            e = 0;
            if (!model_misal(v.sz, v.addr)) begin
                if (v.wr) begin
                    model_store(v.sz, v.addr, v.wdata);
                    e = ref_word(int'((v.addr >> 2) & 32'h3FF));
                end else begin
                    e = model_load(v.sz, v.sg, v.addr);
                end
            end
            run_req(v, o);
            evaluate($sformatf("rnd%0d", i), v, o, e);
        end

        // Word store followed by a load held on ReqValid through the stall.
        bus.ReqValid  = 1'b1;
        bus.ReqWrite  = 1'b1;
        bus.ReqSize   = W;
        bus.ReqSigned = 1'b0;
        bus.ReqAddr   = 32'h20;
        bus.ReqWData  = 32'h1122_3344;
        model_store(W, 32'h20, 32'h1122_3344);
        @(negedge Clk);
        bus.ReqWrite = 1'b0;
        bus.ReqWData = 32'h0;
        o.rdy = 0; o.rv_cnt = 0; o.sd_cnt = 0; o.rv_cyc = 0; o.sd_cyc = 0; o.data = 0;
        for (int k = 1; k <= 6; k++) begin
            if (k == 3) bus.ReqValid = 1'b0;
            o.rdy[k] = bus.ReqReady;
            if (bus.RespValid) begin o.rv_cnt++; if (o.rv_cyc == 0) o.rv_cyc = k; o.data = bus.RespData; end
            if (bus.StoreDone) begin o.sd_cnt++; if (o.sd_cyc == 0) o.sd_cyc = k; end
            @(negedge Clk);
        end
        check("b2b_ready", {25'b0, o.rdy}, {25'b0, 7'b1100100});
        check("b2b_done_cycle", 32'(o.sd_cyc), 32'd2);
        check("b2b_resp_cycle", 32'(o.rv_cyc), 32'd5);
        check("b2b_pulses", pack3(o.rv_cnt, o.sd_cnt, 0), pack3(1, 1, 0));
        check("b2b_data", o.data, model_load(W, 1'b0, 32'h20));

        // Halfword store abandoned by reset while waiting on the read.
        preload(4, 32'h8765_4321);
        bus.ReqValid  = 1'b1;
        bus.ReqWrite  = 1'b1;
        bus.ReqSize   = H;
        bus.ReqSigned = 1'b0;
        bus.ReqAddr   = 32'h10;
        bus.ReqWData  = 32'h0000_7777;
        @(negedge Clk);
        bus.ReqValid = 1'b0;
        @(negedge Clk);
        Reset_n = 1'b0;
        #1;
        check("mid_rst_strobes", {27'b0, bus.RespValid, bus.StoreDone, bus.AddrError, bus.MemWrite, bus.MemRead}, 32'd0);
        check("mid_rst_respdata", bus.RespData, 32'd0);
        check("mid_rst_memaddr", bus.MemAddress, 32'd0);
        check("mid_rst_wdata", bus.MemWriteData, 32'd0);
        cnt_rv = 0; cnt_sd = 0; cnt_wr = 0;
        repeat (2) @(negedge Clk);
        Reset_n = 1'b1;
        for (int k = 0; k < 4; k++) begin
            @(negedge Clk);
            if (k == 0) check("mid_rst_ready", {31'b0, bus.ReqReady}, 32'd1);
            if (bus.RespValid) cnt_rv++;
            if (bus.StoreDone) cnt_sd++;
            if (bus.MemWrite)  cnt_wr++;
        end
        check("mid_rst_quiet", pack3(cnt_rv, cnt_sd, cnt_wr), 32'd0);
        check("mid_rst_mem", mem[4], 32'h8765_4321);
        check("mid_rst_model", mem[4], ref_word(4));

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
